// File: rtl/instr_mem_loader.sv
// Loads a framed byte stream (LEN, N data bytes, CHK) into the instruction RAM.
// Holds the CPU in reset while loading and reports a sticky done/err result.
module instr_mem_loader #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] byte_count
);

    // Longest frame whose last address still fits in the RAM.
    localparam int unsigned MaxLen = (1 << ADDR_W) - 1;

    typedef enum logic [2:0] {StIdle, StLen, StData, StChk, StFin} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic              in_ready_q, in_ready_d;
    logic              wren_q, wren_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              accept;
    logic [DATA_W-1:0] chk_sum;

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        rem_d   = rem_q;
        wren_d  = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = done_q;
        err_d   = err_q;
        count_d = count_q;
        accept  = in_valid && in_ready_q;
        chk_sum = sum_q + in_data;

        // Abort outranks a byte accepted on the same edge.
        if (state_q != StIdle && abort) begin
            state_d = StIdle;
            err_d   = 1'b1;
            done_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && !abort) begin
                        state_d = StLen;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        count_d = '0;
                        sum_d   = '0;
                    end
                end
                StLen: begin
                    if (accept) begin
                        sum_d = in_data;
                        rem_d = in_data;
                        if (in_data == '0 || 32'(in_data) > MaxLen) begin
                            state_d = StFin;
                            err_d   = 1'b1;
                        end else begin
                            state_d = StData;
                        end
                    end
                end
                StData: begin
                    if (accept) begin
                        wren_d  = 1'b1;
                        addr_d  = count_q;
                        data_d  = in_data;
                        count_d = count_q + ADDR_W'(1);
                        sum_d   = sum_q + in_data;
                        rem_d   = rem_q - DATA_W'(1);
                        if (rem_q == DATA_W'(1)) begin
                            state_d = StChk;
                        end
                    end
                end
                StChk: begin
                    if (accept) begin
                        state_d = StFin;
                        if (chk_sum == '0) begin
                            done_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                StFin: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        in_ready_d = (state_d == StLen) || (state_d == StData) || (state_d == StChk);
        hold_d     = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            sum_q      <= '0;
            rem_q      <= '0;
            in_ready_q <= 1'b0;
            wren_q     <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            hold_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            sum_q      <= sum_d;
            rem_q      <= rem_d;
            in_ready_q <= in_ready_d;
            wren_q     <= wren_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
            count_q    <= count_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign mem_addr   = addr_q;
    assign mem_data   = data_q;
    assign mem_wren   = wren_q;
    assign cpu_hold   = hold_q;
    assign done       = done_q;
    assign err        = err_q;
    assign byte_count = count_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: per-cycle vector table plus
// hand-written sequences for stalls, abort and asynchronous reset.
module tb_instr_mem_loader;

    typedef logic [7:0] byte_t;

    typedef struct {
        logic  start;
        logic  abort;
        logic  valid;
        byte_t data;
        logic  rdy;
        logic  wren;
        byte_t addr;
        byte_t wdata;
        logic  hold;
        logic  dn;
        logic  er;
        byte_t bc;
    } vec_t;

    logic  clk = 1'b0;
    logic  resetn = 1'b1;
    logic  start = 1'b0;
    logic  abort = 1'b0;
    logic  in_valid = 1'b0;
    byte_t in_data = 8'h00;
    logic  in_ready;
    byte_t mem_addr;
    byte_t mem_data;
    logic  mem_wren;
    logic  cpu_hold;
    logic  done;
    logic  err;
    byte_t byte_count;

    int    n_total = 0;
    int    n_pass = 0;
    byte_t wr_addr[$];
    byte_t wr_data[$];
    vec_t  vecs[$];
    byte_t frame_nom[$] = '{8'h03, 8'h11, 8'h13, 8'h31, 8'hA8};
    byte_t frame_stall[$] = '{8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF2};

    instr_mem_loader #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .abort      (abort),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_wren   (mem_wren),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err),
        .byte_count (byte_count)
    );

    always #5 clk = ~clk;

    // Write monitor: records every RAM write as seen just after the edge.
    always begin
        @(posedge clk);
        #1;
        if (mem_wren === 1'b1) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic vec_t mk(input logic s, input logic a, input logic v, input byte_t d,
                                input logic r, input logic w, input byte_t ad, input byte_t wd,
                                input logic h, input logic dn, input logic er, input byte_t bc);
        vec_t t;
        t.start = s;  t.abort = a;  t.valid = v;  t.data = d;
        t.rdy = r;    t.wren = w;   t.addr = ad;  t.wdata = wd;
        t.hold = h;   t.dn = dn;    t.er = er;    t.bc = bc;
        return t;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic r, input logic w, input byte_t ad,
                                 input byte_t wd, input logic h, input logic dn, input logic er,
                                 input byte_t bc);
        check({tag, ".in_ready"}, 32'(in_ready), 32'(r));
        check({tag, ".mem_wren"}, 32'(mem_wren), 32'(w));
        check({tag, ".mem_addr"}, 32'(mem_addr), 32'(ad));
        check({tag, ".mem_data"}, 32'(mem_data), 32'(wd));
        check({tag, ".cpu_hold"}, 32'(cpu_hold), 32'(h));
        check({tag, ".done"}, 32'(done), 32'(dn));
        check({tag, ".err"}, 32'(err), 32'(er));
        check({tag, ".byte_count"}, 32'(byte_count), 32'(bc));
    endtask

    // Offers one byte, optionally with random valid stalls; bounded wait for acceptance.
    task automatic send(input byte_t b, input bit stall, input string tag);
        bit acc = 1'b0;
        int guard = 0;
        in_data = b;
        while (!acc && guard < 64) begin
            in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            acc = in_valid && in_ready;
            step();
            guard++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            check({tag, ".accept_timeout"}, 32'd0, 32'd1);
        end
    endtask

    task automatic run_frame(input byte_t fr[$], input bit stall, input string tag);
        start = 1'b1;
        step();
        start = 1'b0;
        foreach (fr[i]) send(fr[i], stall, tag);
        check({tag, ".hold_in_fin"}, 32'(cpu_hold), 32'd1);
        step();
    endtask

    task automatic check_writes(input string tag, input byte_t exp_d[$]);
        check({tag, ".nwrites"}, 32'(wr_addr.size()), 32'(exp_d.size()));
        foreach (exp_d[i]) begin
            if (i < wr_addr.size()) begin
                check($sformatf("%s.addr%0d", tag, i), 32'(wr_addr[i]), 32'(i));
                check($sformatf("%s.data%0d", tag, i), 32'(wr_data[i]), 32'(exp_d[i]));
            end
        end
    endtask

    initial begin
        // Nominal good frame (start pulsed again mid-frame and must be ignored).
        vecs.push_back(mk(1, 0, 0, 8'h00, 1, 0, 8'h00, 8'h00, 1, 0, 0, 8'd0));
        vecs.push_back(mk(0, 0, 1, 8'h03, 1, 0, 8'h00, 8'h00, 1, 0, 0, 8'd0));
        vecs.push_back(mk(0, 0, 1, 8'h11, 1, 1, 8'h00, 8'h11, 1, 0, 0, 8'd1));
        vecs.push_back(mk(1, 0, 1, 8'h13, 1, 1, 8'h01, 8'h13, 1, 0, 0, 8'd2));
        vecs.push_back(mk(0, 0, 1, 8'h31, 1, 1, 8'h02, 8'h31, 1, 0, 0, 8'd3));
        vecs.push_back(mk(0, 0, 1, 8'hA8, 0, 0, 8'h02, 8'h31, 1, 1, 0, 8'd3));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h02, 8'h31, 0, 1, 0, 8'd3));
        vecs.push_back(mk(0, 0, 1, 8'h77, 0, 0, 8'h02, 8'h31, 0, 1, 0, 8'd3));
        // Bad checksum: 02 AA 55 00 sums to 0x01.
        vecs.push_back(mk(1, 0, 0, 8'h00, 1, 0, 8'h02, 8'h31, 1, 0, 0, 8'd0));
        vecs.push_back(mk(0, 0, 1, 8'h02, 1, 0, 8'h02, 8'h31, 1, 0, 0, 8'd0));
        vecs.push_back(mk(0, 0, 1, 8'hAA, 1, 1, 8'h00, 8'hAA, 1, 0, 0, 8'd1));
        vecs.push_back(mk(0, 0, 1, 8'h55, 1, 1, 8'h01, 8'h55, 1, 0, 0, 8'd2));
        vecs.push_back(mk(0, 0, 1, 8'h00, 0, 0, 8'h01, 8'h55, 1, 0, 1, 8'd2));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h01, 8'h55, 0, 0, 1, 8'd2));
        // Zero length frame.
        vecs.push_back(mk(1, 0, 0, 8'h00, 1, 0, 8'h01, 8'h55, 1, 0, 0, 8'd0));
        vecs.push_back(mk(0, 0, 1, 8'h00, 0, 0, 8'h01, 8'h55, 1, 0, 1, 8'd0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h01, 8'h55, 0, 0, 1, 8'd0));
        // start and abort together in IDLE: nothing changes.
        vecs.push_back(mk(1, 1, 0, 8'h00, 0, 0, 8'h01, 8'h55, 0, 0, 1, 8'd0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h01, 8'h55, 0, 0, 1, 8'd0));

        #1 resetn = 1'b0;
        #2;
        check_outputs("reset", 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'd0);
        step();
        step();
        resetn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            start    = vecs[i].start;
            abort    = vecs[i].abort;
            in_valid = vecs[i].valid;
            in_data  = vecs[i].data;
            step();
            check_outputs($sformatf("v%0d", i), vecs[i].rdy, vecs[i].wren, vecs[i].addr,
                          vecs[i].wdata, vecs[i].hold, vecs[i].dn, vecs[i].er, vecs[i].bc);
        end
        start = 1'b0;
        abort = 1'b0;
        in_valid = 1'b0;

        // Stalling host.
        wr_addr.delete();
        wr_data.delete();
        run_frame(frame_stall, 1'b1, "stall");
        check_outputs("stall.end", 0, 0, 8'h03, 8'h04, 0, 1, 0, 8'd4);
        check_writes("stall", '{8'h01, 8'h02, 8'h03, 8'h04});

        // Abort after 2 of 5 data bytes, with a byte offered on the abort edge.
        wr_addr.delete();
        wr_data.delete();
        start = 1'b1;
        step();
        start = 1'b0;
        send(8'h05, 1'b0, "abort");
        send(8'hA1, 1'b0, "abort");
        send(8'hA2, 1'b0, "abort");
        abort = 1'b1;
        in_valid = 1'b1;
        in_data = 8'hA3;
        step();
        abort = 1'b0;
        in_valid = 1'b0;
        check_outputs("abort.end", 0, 0, 8'h01, 8'hA2, 0, 0, 1, 8'd2);
        step();
        check_writes("abort", '{8'hA1, 8'hA2});
        wr_addr.delete();
        wr_data.delete();
        run_frame(frame_nom, 1'b0, "after_abort");
        check_outputs("after_abort.end", 0, 0, 8'h02, 8'h31, 0, 1, 0, 8'd3);
        check_writes("after_abort", '{8'h11, 8'h13, 8'h31});

        // Asynchronous reset in the middle of DATA.
        start = 1'b1;
        step();
        start = 1'b0;
        send(8'h03, 1'b0, "arst");
        send(8'h11, 1'b0, "arst");
        check({"arst", ".wren_before"}, 32'(mem_wren), 32'd1);
        #2 resetn = 1'b0;
        #1;
        check_outputs("arst", 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'd0);
        #2 resetn = 1'b1;
        step();
        wr_addr.delete();
        wr_data.delete();
        run_frame(frame_nom, 1'b0, "after_arst");
        check_outputs("after_arst.end", 0, 0, 8'h02, 8'h31, 0, 1, 0, 8'd3);
        check_writes("after_arst", '{8'h11, 8'h13, 8'h31});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
